// File: rtl/uart_msg_tx_341457971277988435_pkg.sv
// Shared types for the fixed-message UART transmitter.
// FSM encoding, parity codes and a counter width helper.
package uart_msg_tx_341457971277988435_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_GAP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Width of a counter holding 0..n-1, never below one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_msg_tx_341457971277988435_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0.
// tick marks the last cycle of every bit; load holds it at the top.
module uart_bit_timer_341457971277988435
   import uart_msg_tx_341457971277988435_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic tick
);

   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Down-counter, reloaded on load or after terminal count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load || cnt == '0) begin
         cnt <= TOP;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_msg_tx_341457971277988435.sv
// Fixed-message UART transmitter with parity, stop bits and gaps.
// All outputs are registered from the next-state logic.
module uart_msg_tx_341457971277988435
   import uart_msg_tx_341457971277988435_pkg::*;
#(
   parameter int                   MSG_LEN      = 13,
   parameter logic [8*MSG_LEN-1:0] MSG          = "Hello World!\n",
   parameter int                   CLKS_PER_BIT = 1,
   parameter int                   DATA_BITS    = 8,
   parameter int                   PARITY       = 0,
   parameter int                   STOP_BITS    = 1,
   parameter int                   CHAR_GAP     = 1,
   parameter int                   MSG_GAP      = 11
)(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic repeat_en,
   output logic uart_tx,
   output logic busy,
   output logic done
);

   localparam int IW = cnt_w(MSG_LEN);
   localparam int GW = cnt_w(CHAR_GAP + MSG_GAP + 1);

   localparam logic [7:0]    DMASK = 8'((1 << DATA_BITS) - 1);
   localparam logic [2:0]    DLAST = 3'(DATA_BITS - 1);
   localparam logic [IW-1:0] ILAST = IW'(MSG_LEN - 1);
   localparam logic [GW-1:0] GAP_C = GW'(CHAR_GAP);
   localparam logic [GW-1:0] GAP_M = GW'(MSG_GAP);
   localparam logic          SLAST = (STOP_BITS == 2);

   state_t        state;
   state_t        state_n;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_n;
   logic          stop_idx;
   logic          stop_idx_n;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_cnt_n;
   logic [IW-1:0] char_idx;
   logic [IW-1:0] char_idx_n;
   logic          tx_n;
   logic          busy_n;
   logic          done_n;
   logic          char_end;

   logic          tick;
   logic          load;
   logic [7:0]    chr;
   logic          par_bit;
   logic          last;
   logic [GW-1:0] gap_len;

   assign load = (state == S_IDLE);

   uart_bit_timer_341457971277988435 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .tick (tick)
   );

   // Current character, its parity and the gap owed after it.
   always_comb begin
      chr     = MSG[8*(MSG_LEN-1-int'(char_idx)) +: 8];
      par_bit = (^(chr & DMASK)) ^ (PARITY == PAR_ODD);
      last    = (char_idx == ILAST);
      gap_len = GAP_C + (last ? GAP_M : '0);
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_n    = state;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      gap_cnt_n  = gap_cnt;
      char_idx_n = char_idx;
      done_n     = 1'b0;
      char_end   = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start || repeat_en) begin
               state_n    = S_START;
               char_idx_n = '0;
            end
         end
         S_START: begin
            if (tick) begin
               state_n   = S_DATA;
               bit_idx_n = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_idx == DLAST) begin
                  state_n    = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                  stop_idx_n = 1'b0;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               state_n    = S_STOP;
               stop_idx_n = 1'b0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop_idx == SLAST) begin
                  if (gap_len != '0) begin
                     state_n   = S_GAP;
                     gap_cnt_n = gap_len - GW'(1);
                  end else begin
                     char_end = 1'b1;
                  end
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (tick) begin
               if (gap_cnt == '0) begin
                  char_end = 1'b1;
               end else begin
                  gap_cnt_n = gap_cnt - GW'(1);
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (char_end) begin
         if (last) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
         end else begin
            state_n    = S_START;
            char_idx_n = char_idx + IW'(1);
         end
      end

      unique case (state_n)
         S_START: tx_n = 1'b0;
         S_DATA:  tx_n = chr[bit_idx_n];
         S_PAR:   tx_n = par_bit;
         default: tx_n = 1'b1;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         gap_cnt  <= '0;
         char_idx <= '0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         gap_cnt  <= gap_cnt_n;
         char_idx <= char_idx_n;
         uart_tx  <= tx_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_uart_msg_tx_341457971277988435.sv
// Bench for uart_msg_tx_341457971277988435: four configurations,
// frame scoreboard plus done/busy timing.
module tb_uart_msg_tx_341457971277988435;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] st = '0;
   logic [3:0] rp = '0;
   logic [3:0] rs = '0;
   logic tx0, tx1, tx2, tx3;
   logic bz0, bz1, bz2, bz3;
   logic dn0, dn1, dn2, dn3;
   logic [3:0] tx, bz, dn;
   assign tx = {tx3, tx2, tx1, tx0};
   assign bz = {bz3, bz2, bz1, bz0};
   assign dn = {dn3, dn2, dn1, dn0};

   int CPB[4] = '{1, 4, 4, 1};
   int DBW[4] = '{8, 8, 8, 7};
   int PRT[4] = '{0, 1, 2, 0};
   int STB[4] = '{1, 2, 2, 1};
   int CG[4]  = '{1, 1, 1, 0};
   int MG[4]  = '{11, 11, 11, 0};

   uart_msg_tx_341457971277988435 u0 (
      .clk(clk), .reset(rs[0]), .start(st[0]), .repeat_en(rp[0]),
      .uart_tx(tx0), .busy(bz0), .done(dn0));

   uart_msg_tx_341457971277988435 #(
      .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)
   ) u1 (
      .clk(clk), .reset(rs[1]), .start(st[1]), .repeat_en(rp[1]),
      .uart_tx(tx1), .busy(bz1), .done(dn1));

   uart_msg_tx_341457971277988435 #(
      .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)
   ) u2 (
      .clk(clk), .reset(rs[2]), .start(st[2]), .repeat_en(rp[2]),
      .uart_tx(tx2), .busy(bz2), .done(dn2));

   uart_msg_tx_341457971277988435 #(
      .DATA_BITS(7), .CHAR_GAP(0), .MSG_GAP(0)
   ) u3 (
      .clk(clk), .reset(rs[3]), .start(st[3]), .repeat_en(rp[3]),
      .uart_tx(tx3), .busy(bz3), .done(dn3));

   typedef struct {
      int i;
      int cyc;
      int ch;
   } exp_t;

   exp_t  q[$];
   int    checks = 0;
   int    errors = 0;
   int    dcnt[4] = '{default: 0};
   int    dexp[4] = '{default: 0};
   string msg = "Hello World!\n";

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                  name, got, want, cyc);
      end
   endtask

   function automatic int flen(input int i);
      return 1 + DBW[i] + ((PRT[i] != 0) ? 1 : 0) + STB[i];
   endfunction

   function automatic int mlen(input int i);
      return (13 * (flen(i) + CG[i]) + MG[i]) * CPB[i];
   endfunction

   task automatic push_chars(input int i, input int s, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.i   = i;
         e.cyc = s + k * (flen(i) + CG[i]) * CPB[i];
         e.ch  = int'(msg[k]);
         q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) if (dn[i]) dcnt[i]++;
   end

   // Frame monitor: decodes one instance's line and scores each frame.
   task automatic mon(input int i);
      int c, f, t, mask;
      logic prev, bad, abort, p, ok;
      logic [15:0] bits;
      logic [7:0] d;
      exp_t e;
      c = CPB[i];
      f = flen(i);
      mask = (1 << DBW[i]) - 1;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rs[i] && prev && !tx[i]) begin
            t = cyc;
            bits = '0;
            bad = 1'b0;
            abort = 1'b0;
            for (int b = 0; b < f; b++) begin
               for (int k = 0; k < c; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  if (!rs[i]) abort = 1'b1;
                  if (k == 0) bits[b] = tx[i];
                  else if (tx[i] != bits[b]) bad = 1'b1;
               end
            end
            prev = tx[i];
            if (!abort) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: inst %0d at cycle %0d, none queued",
                           i, t);
               end else begin
                  e = q.pop_front();
                  chk("frame_inst", i, e.i);
                  chk("start_cyc", t, e.cyc);
                  chk("bit_width", int'(bad), 0);
                  d = '0;
                  for (int b = 0; b < DBW[i]; b++) d[b] = bits[b+1];
                  chk("data", int'(d), e.ch & mask);
                  if (PRT[i] != 0) begin
                     p = ^(e.ch & mask);
                     if (PRT[i] == 2) p = !p;
                     chk("parity", int'(bits[DBW[i]+1]), int'(p));
                  end
                  ok = 1'b1;
                  for (int k = 0; k < STB[i]; k++) if (!bits[f-1-k]) ok = 1'b0;
                  chk("stop", int'(ok), 1);
               end
            end
         end else begin
            prev = tx[i];
         end
      end
   endtask

   task automatic wait_done(input int i, input int want);
      int n;
      n = 0;
      while (!dn[i] && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!dn[i]) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: inst %0d got no done, want cycle %0d",
                  i, want);
      end else begin
         chk("done_cyc", cyc, want);
         chk("busy_fall", int'(bz[i]), 0);
      end
      dexp[i]++;
      @(negedge clk);
   endtask

   task automatic run_msg(input int i, input bit wave);
      int s;
      logic [10:0] w;
      @(negedge clk);
      s = cyc + 1;
      push_chars(i, s, 13);
      st[i] = 1'b1;
      @(negedge clk);
      st[i] = 1'b0;
      chk("busy_rise", int'(bz[i]), 1);
      if (wave) begin
         w = '0;
         for (int k = 0; k < 11; k++) begin
            if (k != 0) @(negedge clk);
            w = {w[9:0], tx[i]};
         end
         chk("h_wave", int'(w), 'b00001001011);
      end
      while (cyc < s + 20) @(negedge clk);
      st[i] = 1'b1;
      @(negedge clk);
      st[i] = 1'b0;
      wait_done(i, s + mlen(i));
   endtask

   initial begin
      int s, bad;
      fork
         mon(0);
         mon(1);
         mon(2);
         mon(3);
      join_none

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("rst_tx", int'(tx[i]), 1);
         chk("rst_busy", int'(bz[i]), 0);
         chk("rst_done", int'(dn[i]), 0);
      end
      rs = 4'hF;
      repeat (3) @(negedge clk);

      run_msg(0, 1'b1);
      run_msg(1, 1'b0);
      run_msg(2, 1'b0);
      run_msg(3, 1'b0);

      // repeat_en held for one full period, dropped mid second message
      @(negedge clk);
      s = cyc + 1;
      push_chars(0, s, 13);
      push_chars(0, s + 155, 13);
      rp[0] = 1'b1;
      @(negedge clk);
      while (cyc < s + 60) @(negedge clk);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      while (cyc < s + 205) @(negedge clk);
      rp[0] = 1'b0;
      dexp[0]++;
      wait_done(0, s + 155 + 154);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx[0] !== 1'b1 || bz[0] !== 1'b0) bad++;
      end
      chk("idle_after_repeat", bad, 0);

      // reset during a zero data bit of character 5 ('o')
      @(negedge clk);
      s = cyc + 1;
      push_chars(0, s, 4);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      while (cyc < s + 49) @(negedge clk);
      chk("pre_rst_tx", int'(tx[0]), 0);
      rs[0] = 1'b0;
      #1;
      chk("rst_mid_tx", int'(tx[0]), 1);
      chk("rst_mid_busy", int'(bz[0]), 0);
      repeat (5) @(negedge clk);
      rs[0] = 1'b1;
      repeat (20) @(negedge clk);
      run_msg(0, 1'b1);

      repeat (5) @(negedge clk);
      chk("queue_left", q.size(), 0);
      for (int i = 0; i < 4; i++) chk("done_count", dcnt[i], dexp[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
